// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: ctrl/data bundles, valid/ready flow control, two-entry skid buffer, flush-to-bubble.
// Optional statistics counters (stall/bubble/flush) are built when PIPE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_DATA = 1'b0
`ifdef PIPE_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;

  state_t              w_state_nxt;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic                w_accept;
  logic                w_drain;

  assign w_accept  = in_valid & r_in_ready;
  assign w_drain   = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

  // Next-state and entry update; flush wins over any handshake and discards the offered beat
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (flush) begin
      w_state_nxt     = S_EMPTY;
      w_main_ctrl_nxt = {CTRL_W{1'b0}};
      w_skid_ctrl_nxt = {CTRL_W{1'b0}};
      if (CLEAR_DATA) begin
        w_main_data_nxt = {DATA_W{1'b0}};
        w_skid_data_nxt = {DATA_W{1'b0}};
      end else begin
        w_main_data_nxt = r_main_data;
        w_skid_data_nxt = r_skid_data;
      end
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = S_ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else begin
            w_state_nxt     = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_accept) begin
            w_state_nxt     = S_FULL;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_drain) begin
            w_state_nxt     = S_EMPTY;
            w_main_ctrl_nxt = {CTRL_W{1'b0}};
            if (CLEAR_DATA) begin
              w_main_data_nxt = {DATA_W{1'b0}};
            end else begin
              w_main_data_nxt = r_main_data;
            end
          end else begin
            w_state_nxt     = S_ONE;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            w_state_nxt     = S_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
          end else begin
            w_state_nxt     = S_FULL;
          end
        end
        default: begin
          w_state_nxt     = S_EMPTY;
          w_main_ctrl_nxt = {CTRL_W{1'b0}};
          w_skid_ctrl_nxt = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State and entry registers; handshake flags are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_main_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

`ifdef PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

  // Saturating event counters; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
      r_flush_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!r_out_valid && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
      if (flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard of accepted beats compared on each downstream drain.
// Two instances share stimulus, one with CLEAR_DATA=0 and one with CLEAR_DATA=1.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
`ifdef PIPE_STATS_EN
  logic [3:0]    stall_cnt0, bubble_cnt0, flush_cnt0;
  logic [3:0]    stall_cnt1, bubble_cnt1, flush_cnt1;
`endif

  int n_checks;
  int n_errors;

  logic [CW+DW-1:0] sbq[$];
  logic             sb_drained;
  logic [CW+DW-1:0] sb_obs;
  logic [CW+DW-1:0] sb_exp;

  pipe_stage_reg #(
`ifdef PIPE_STATS_EN
    .CNT_W(4),
`endif
    .CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0), .flush_cnt(flush_cnt0)
`endif
  );

  pipe_stage_reg #(
`ifdef PIPE_STATS_EN
    .CNT_W(4),
`endif
    .CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(input logic [CW-1:0] c);
    return {~c, c};
  endfunction

  // One clock: record drain/accept on the scoreboard from the values about to be sampled, then advance.
  task automatic tick();
    sb_drained = out_valid0 && out_ready;
    sb_obs     = {out_ctrl0, out_data0};
    sb_exp     = 'x;
    if (sb_drained && sbq.size() > 0) sb_exp = sbq.pop_front();
    if (flush) sbq.delete();
    else if (in_valid && in_ready0) sbq.push_back({in_ctrl, in_data});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = dat(c);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; drive(1'b1, 16'hBEEF); out_ready = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0; flush = 1'b0; drive(1'b0, 16'h0000);
    sbq.delete();
    n_checks++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h0000 || out_data0 !== 32'h0 || in_ready0 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b c=%h d=%h r=%b required v=0 c=0000 d=0 r=1",
               out_valid0, out_ctrl0, out_data0, in_ready0);
    end
`ifdef PIPE_STATS_EN
    n_checks++;
    if (stall_cnt0 !== 4'd0 || bubble_cnt0 !== 4'd0 || flush_cnt0 !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_counters: got %0d %0d %0d required 0 0 0", stall_cnt0, bubble_cnt0, flush_cnt0);
    end
`endif
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i));
      n_checks++;
      if (in_ready0 !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_in_ready: beat %0d got %b required 1", i, in_ready0);
      end
      tick();
      if (i > 1) begin
        n_checks++;
        if (!sb_drained || sb_obs !== sb_exp) begin
          n_errors++;
          $display("FAIL stream_drain: beat %0d got %h required %h", i - 1, sb_obs, sb_exp);
        end
      end
      n_checks++;
      if (out_valid0 !== 1'b1 || out_ctrl0 !== CW'(i)) begin
        n_errors++;
        $display("FAIL stream_latency: got v=%b c=%h required v=1 c=%h", out_valid0, out_ctrl0, CW'(i));
      end
    end
    drive(1'b0, 16'h0000);
    tick();
    n_checks++;
    if (!sb_drained || sb_obs !== sb_exp) begin
      n_errors++;
      $display("FAIL stream_last_drain: got %h required %h", sb_obs, sb_exp);
    end
    n_checks++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h0000) begin
      n_errors++;
      $display("FAIL stream_empty: got v=%b c=%h required v=0 c=0000", out_valid0, out_ctrl0);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 16'h00A1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h00B2);
    tick();
    drive(1'b1, 16'h00C3);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid0 !== 1'b1 || out_ctrl0 !== 16'h00A1 || out_data0 !== dat(16'h00A1) || in_ready0 !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold: got v=%b c=%h r=%b required v=1 c=00a1 r=0", out_valid0, out_ctrl0, in_ready0);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (!sb_drained || sb_obs !== {16'h00A1, dat(16'h00A1)}) begin
      n_errors++;
      $display("FAIL release_a: got %h required A", sb_obs);
    end
    n_checks++;
    if (in_ready0 !== 1'b1 || out_ctrl0 !== 16'h00B2) begin
      n_errors++;
      $display("FAIL release_ready: got r=%b c=%h required r=1 c=00b2", in_ready0, out_ctrl0);
    end
    tick();
    n_checks++;
    if (!sb_drained || sb_obs !== sb_exp || sb_obs[DW+CW-1:DW] !== 16'h00B2) begin
      n_errors++;
      $display("FAIL release_b: got %h required %h", sb_obs, sb_exp);
    end
    drive(1'b0, 16'h0000);
    tick();
    n_checks++;
    if (!sb_drained || sb_obs !== sb_exp || sb_obs[DW+CW-1:DW] !== 16'h00C3) begin
      n_errors++;
      $display("FAIL release_c: got %h required %h", sb_obs, sb_exp);
    end
    n_checks++;
    if (out_valid0 !== 1'b0 || sbq.size() != 0) begin
      n_errors++;
      $display("FAIL release_empty: got v=%b queue=%0d required v=0 queue=0", out_valid0, sbq.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 16'h00D4); tick();
    drive(1'b1, 16'h00E5); tick();
    flush = 1'b1; drive(1'b1, 16'hFFFF);
    tick();
    flush = 1'b0; drive(1'b0, 16'h0000);
    n_checks++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h0000 || in_ready0 !== 1'b1 || out_data0 !== dat(16'h00D4)) begin
      n_errors++;
      $display("FAIL flush_full_keep: got v=%b c=%h r=%b d=%h required v=0 c=0000 r=1 d=%h",
               out_valid0, out_ctrl0, in_ready0, out_data0, dat(16'h00D4));
    end
    n_checks++;
    if (out_valid1 !== 1'b0 || out_ctrl1 !== 16'h0000 || in_ready1 !== 1'b1 || out_data1 !== 32'h0) begin
      n_errors++;
      $display("FAIL flush_full_clear: got v=%b c=%h r=%b d=%h required v=0 c=0000 r=1 d=0",
               out_valid1, out_ctrl1, in_ready1, out_data1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid0 !== 1'b0 || out_ctrl0 === 16'hFFFF) begin
        n_errors++;
        $display("FAIL flush_no_ghost: got v=%b c=%h required v=0", out_valid0, out_ctrl0);
      end
    end
    out_ready = 1'b0;
    drive(1'b1, 16'hF0F0); tick();
    flush = 1'b1; drive(1'b1, 16'hFFFF);
    tick();
    flush = 1'b0; drive(1'b0, 16'h0000);
    tick();
    n_checks++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h0000 || in_ready0 !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_one_discard: got v=%b c=%h r=%b required v=0 c=0000 r=1", out_valid0, out_ctrl0, in_ready0);
    end
  endtask

  task automatic test_rst_flush();
    out_ready = 1'b0;
    drive(1'b1, 16'h0101); tick();
    drive(1'b1, 16'h0202); tick();
    rst = 1'b1; flush = 1'b1; drive(1'b1, 16'h0303);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; flush = 1'b0; drive(1'b0, 16'h0000);
    sbq.delete();
    n_checks++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h0000 || out_data0 !== 32'h0 || in_ready0 !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_over_flush: got v=%b c=%h d=%h r=%b required all zero, r=1",
               out_valid0, out_ctrl0, out_data0, in_ready0);
    end
    out_ready = 1'b1;
    drive(1'b1, 16'h0055); tick();
    drive(1'b0, 16'h0000); tick();
    n_checks++;
    if (!sb_drained || sb_obs !== {16'h0055, dat(16'h0055)}) begin
      n_errors++;
      $display("FAIL after_rst_beat: got %h required %h", sb_obs, {16'h0055, dat(16'h0055)});
    end
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; flush = 1'b0; drive(1'b0, 16'h0000); out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    drive(1'b1, 16'h0033); tick();
    drive(1'b0, 16'h0000);
    repeat (14) tick();
    n_checks++;
    if (stall_cnt0 !== 4'd14) begin
      n_errors++;
      $display("FAIL stall_count: got %0d required 14", stall_cnt0);
    end
    repeat (6) tick();
    n_checks++;
    if (stall_cnt0 !== 4'd15 || bubble_cnt0 !== 4'd1) begin
      n_errors++;
      $display("FAIL stall_saturate: got stall=%0d bubble=%0d required 15 1", stall_cnt0, bubble_cnt0);
    end
    flush = 1'b1;
    repeat (3) tick();
    flush = 1'b0;
    n_checks++;
    if (flush_cnt0 !== 4'd3 || stall_cnt0 !== 4'd15 || bubble_cnt0 !== 4'd3) begin
      n_errors++;
      $display("FAIL flush_count: got flush=%0d stall=%0d bubble=%0d required 3 15 3",
               flush_cnt0, stall_cnt0, bubble_cnt0);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_rst_flush();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage MIPS datapath. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a control field and a data field with valid/ready flow control. A two-entry skid buffer keeps `in_ready` registered, and flush inserts a bubble. Each pipeline boundary instantiates it with its own widths.

## Interface
- `CTRL_W`, default 16: width of the control bundle (regWrite, MemRead, MemWrite, ALUOp, …). It is zeroed on every bubble.
- `DATA_W`, default 128: width of the data bundle (PC+4, ReadData1/2, offset, register indices, …).
- `CLEAR_DATA`, default 0: 1 zeroes the data field on flush or drain; 0 holds the stale data.
- `CNT_W`, default 16: width of the statistics counters (used only with `PIPE_STATS_EN`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash all held entries (branch/jump taken, hazard bubble).
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept; driven only by registered state.
- `in_ctrl`  in  `CTRL_W`  upstream control bundle.
- `in_data`  in  `DATA_W`  upstream data bundle.
- `out_valid`  out  1  entry presented downstream.
- `out_ready`  in  1  downstream accepts (a low value is a stall).
- `out_ctrl`  out  `CTRL_W`  control bundle; all-zero whenever `out_valid`=0.
- `out_data`  out  `DATA_W`  data bundle.
- `stall_cnt`, `bubble_cnt`, `flush_cnt`  out  `CNT_W` each  present only with `PIPE_STATS_EN`.

## Operation
- Storage:
  - Main entry drives `out_*`.
  - Skid entry captures one extra beat while downstream stalls.
  - State encodes occupancy: EMPTY, ONE, FULL.
- `in_ready` = (state != FULL). `out_valid` = (state != EMPTY).
- Accept = `in_valid` & `in_ready`. Drain = `out_valid` & `out_ready`.
- Transitions (priority: `rst` > `flush` > normal):
  - EMPTY:
    - accept → load main, go ONE.
    - otherwise stay.
  - ONE:
    - accept & drain → main←in, stay ONE.
    - accept & !drain → skid←in, go FULL.
    - !accept & drain → go EMPTY.
    - otherwise hold.
  - FULL:
    - drain → main←skid, go ONE. No accept is possible because `in_ready`=0.
    - otherwise hold both entries.
- On entering EMPTY, main ctrl is cleared to 0. Main data is cleared only if `CLEAR_DATA`=1.
- `flush`:
  - Next state is EMPTY.
  - Main and skid ctrl go to 0; data goes to 0 if `CLEAR_DATA`=1.
  - A beat offered in the same cycle (`in_valid`&`in_ready`) is discarded, not stored.
  - A downstream drain in the flush cycle still completes; the consumer has already sampled `out_*`.
- `rst`:
  - State EMPTY.
  - All ctrl and data registers, including skid, go to 0 regardless of `CLEAR_DATA`.
  - Counters go to 0.
  - Overrides `flush` and all handshakes.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by `flush`/`rst`.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1.
- `in_ready` has no combinational path from `out_ready`, `in_valid` or `flush`.
  - It falls the cycle after the second beat is captured during a stall.
  - It rises the cycle after the first drain from FULL.
- Output values after `rst`: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1, counters=0.
- Flush-to-empty takes effect at the next edge. In the following cycle `out_valid`=0 and `in_ready`=1.
- Held outputs stay stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `PIPE_STATS_EN` defined: the three counters are built.
  - `stall_cnt` +1 per cycle with `out_valid` & !`out_ready`.
  - `bubble_cnt` +1 per cycle with !`out_valid`.
  - `flush_cnt` +1 per cycle with `flush`=1.
  - All saturate at 2^`CNT_W`−1.
  - `rst` clears them; `flush` does not.
- `PIPE_STATS_EN` undefined: counter ports and logic are absent. Datapath behaviour is identical.

## Test plan
- Reset, then stream 8 beats, ctrl=`16'h0001`..`16'h0008`, with `out_ready`=1 → one output per cycle in order, 1-cycle latency, `in_ready` constantly 1.
- Stream beats A, B, C; hold `out_ready`=0 from the cycle A is presented → A held, B in skid, `in_ready`=0, C held upstream. Release → A, B, C appear on consecutive cycles.
- FULL state with `flush`=1 and `in_valid`=1 (ctrl=`16'hFFFF`) → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and `16'hFFFF` never appears.
- `CLEAR_DATA`=0 flush → `out_data` keeps the last value and `out_ctrl`=0. With `CLEAR_DATA`=1 → `out_data`=0.
- `rst` asserted together with `flush` while FULL, `CLEAR_DATA`=0 → all outputs 0 next cycle, including data.
- `PIPE_STATS_EN`, `CNT_W`=4: hold a stall for 20 cycles → `stall_cnt` saturates at 15. Then 3 flush cycles → `flush_cnt`=3, and `stall_cnt` is unchanged by the flush.
